// File: rtl/gbuf_pkg.sv
// Shared types and constants for the operand-A global buffer loader.
package gbuf_pkg;
    localparam int NUM_BANKS      = 8;
    localparam int BANK_DEPTH     = 2048;
    localparam int GBUF_ADDR_BITS = 16;

    typedef logic [2:0]                bank_t;
    typedef logic [GBUF_ADDR_BITS-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH
    } ld_state_t;
endpackage

// File: rtl/gbuf_addr_gen.sv
// Bank/address walker: loads a start point, steps one word per advance,
// spills into the next bank at the end of a bank and flags running off the last bank.
module gbuf_addr_gen
    import gbuf_pkg::*;
#(
    parameter int ADDR_BITS  = 16,
    parameter int NUM_BANKS  = gbuf_pkg::NUM_BANKS,
    parameter int BANK_DEPTH = gbuf_pkg::BANK_DEPTH
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  bank_t                i_bank,
    input  logic [ADDR_BITS-1:0] i_base,
    input  logic                 i_advance,
    output bank_t                o_bank,
    output logic [ADDR_BITS-1:0] o_addr,
    output logic                 o_overflow
);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(BANK_DEPTH - 1);
    localparam bank_t                LAST_BANK = bank_t'(NUM_BANKS - 1);
    localparam logic [3:0]           BANK_LIM  = 4'(NUM_BANKS);

    bank_t                r_bank;
    logic [ADDR_BITS-1:0] r_addr;
    logic                 r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank     <= '0;
            r_addr     <= '0;
            r_overflow <= 1'b0;
        end else if (i_load) begin
            r_bank     <= i_bank;
            r_addr     <= i_base;
            r_overflow <= ({1'b0, i_bank} >= BANK_LIM);
        end else if (i_advance) begin
            if (r_addr == LAST_ADDR) begin
                r_addr <= '0;
                r_bank <= r_bank + bank_t'(1);
                // sticky: once past the last bank nothing further is addressable
                if (r_bank == LAST_BANK)
                    r_overflow <= 1'b1;
            end else begin
                r_addr <= r_addr + ADDR_BITS'(1);
            end
        end
    end

    assign o_bank     = r_bank;
    assign o_addr     = r_addr;
    assign o_overflow = r_overflow;
endmodule

// File: rtl/gbuf_a_loader.sv
// Streaming write front end for the operand-A global buffer banks.
// Optional running checksum output enabled by GBUF_LOADER_CSUM_EN.
module gbuf_a_loader
    import gbuf_pkg::*;
#(
    parameter int ADDR_BITS  = 16,
    parameter int DATA_BITS  = 32,
    parameter int NUM_BANKS  = gbuf_pkg::NUM_BANKS,
    parameter int BANK_DEPTH = gbuf_pkg::BANK_DEPTH
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [2:0]           cfg_bank,
    input  logic [ADDR_BITS-1:0] cfg_base,
    input  logic [ADDR_BITS-1:0] cfg_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] index,
    output logic [DATA_BITS-1:0] data_in,
    output logic [2:0]           buf_idx,
    output logic                 busy,
    output logic                 done,
`ifdef GBUF_LOADER_CSUM_EN
    output logic [DATA_BITS-1:0] csum,
`endif
    output logic                 overflow
);
    ld_state_t            r_state, w_next;
    logic [ADDR_BITS-1:0] r_rem;
    logic                 r_hs_d;
    logic                 r_wr_en;
    logic [ADDR_BITS-1:0] r_index;
    logic [DATA_BITS-1:0] r_data;
    bank_t                r_buf_idx;

    logic                 w_accept, w_hs, w_ovf;
    bank_t                w_bank;
    logic [ADDR_BITS-1:0] w_addr;

    assign w_accept = cfg_valid & (r_state == IDLE);
    assign w_hs     = in_valid & (r_state == LOAD);

    gbuf_addr_gen #(
        .ADDR_BITS  (ADDR_BITS),
        .NUM_BANKS  (NUM_BANKS),
        .BANK_DEPTH (BANK_DEPTH)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_bank     (cfg_bank),
        .i_base     (cfg_base),
        .i_advance  (w_hs),
        .o_bank     (w_bank),
        .o_addr     (w_addr),
        .o_overflow (w_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // FLUSH waits out the final write cycle so done lands after it
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = (cfg_len == '0) ? FLUSH : LOAD;
            LOAD:    if (w_hs && r_rem == ADDR_BITS'(1)) w_next = FLUSH;
            FLUSH:   if (!r_hs_d) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem     <= '0;
            r_hs_d    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_index   <= '0;
            r_data    <= '0;
            r_buf_idx <= '0;
        end else begin
            r_hs_d  <= w_hs;
            r_wr_en <= w_hs & ~w_ovf;
            if (w_accept)  r_rem <= cfg_len;
            else if (w_hs) r_rem <= r_rem - ADDR_BITS'(1);
            // dropped overflow words leave the bank bus untouched
            if (w_hs && !w_ovf) begin
                r_index   <= w_addr;
                r_buf_idx <= w_bank;
                r_data    <= in_data;
            end
        end
    end

`ifdef GBUF_LOADER_CSUM_EN
    logic [DATA_BITS-1:0] r_csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_csum <= '0;
        else if (w_accept) r_csum <= '0;
        else if (w_hs)     r_csum <= r_csum + in_data;
    end

    assign csum = r_csum;
`endif

    assign cfg_ready = (r_state == IDLE);
    assign in_ready  = (r_state == LOAD);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == FLUSH) & ~r_hs_d;
    assign overflow  = w_ovf;
    assign wr_en     = r_wr_en;
    assign index     = r_index;
    assign data_in   = r_data;
    assign buf_idx   = r_buf_idx;
endmodule

// File: tb/tb_gbuf_a_loader.sv
// Directed bench for gbuf_a_loader with a negedge-write bank model.
module tb_gbuf_a_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [2:0]  cfg_bank = '0;
    logic [15:0] cfg_base = '0;
    logic [15:0] cfg_len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        wr_en;
    logic [15:0] index;
    logic [31:0] data_in;
    logic [2:0]  buf_idx;
    logic        busy;
    logic        done;
    logic        overflow;
`ifdef GBUF_LOADER_CSUM_EN
    logic [31:0] csum;
`endif

    gbuf_a_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_bank  (cfg_bank),
        .cfg_base  (cfg_base),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .wr_en     (wr_en),
        .index     (index),
        .data_in   (data_in),
        .buf_idx   (buf_idx),
        .busy      (busy),
        .done      (done),
`ifdef GBUF_LOADER_CSUM_EN
        .csum      (csum),
`endif
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [2:0]  bank;
        logic [15:0] idx;
        logic [31:0] data;
    } wr_t;

    wr_t         wq[$];
    int          dq[$];
    logic [31:0] mem [8][2048];
    logic [31:0] csum_at_done = '0;

    // bank model: the real banks capture on negedge
    always @(negedge clk) begin
        if (wr_en) begin
            wq.push_back('{cyc, buf_idx, index, data_in});
            mem[buf_idx][index[10:0]] = data_in;
        end
        if (done) begin
            dq.push_back(cyc);
`ifdef GBUF_LOADER_CSUM_EN
            csum_at_done = csum;
`endif
        end
    end

    int          total = 0;
    int          bad = 0;
    int          acc;
    logic [31:0] tx[$];

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_desc(input logic [2:0] b, input logic [15:0] base, input logic [15:0] len);
        bit rdy;
        int n;
        n = 0;
        cfg_bank = b; cfg_base = base; cfg_len = len; cfg_valid = 1'b1;
        do begin
            rdy = cfg_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 50);
        total++;
        if (!rdy) begin
            bad++;
            $display("FAIL desc_accept: cfg_ready never seen, required 1");
        end
        acc = cyc;
        cfg_valid = 1'b0;
    endtask

    task automatic stream(input bit gaps);
        foreach (tx[i]) begin
            bit rdy;
            int n;
            n = 0;
            in_valid = 1'b1;
            in_data  = tx[i];
            do begin
                rdy = in_ready;
                @(posedge clk); #1;
                n++;
            end while (!rdy && n < 50);
            if (!rdy) begin
                total++; bad++;
                $display("FAIL stream_ready: word %0d never accepted", i);
            end
            if (gaps) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({wr_en, index, data_in, buf_idx, busy, done, overflow, in_ready, cfg_ready} !== {1'b0, 16'h0, 32'h0, 3'h0, 5'b00001}) begin
            bad++;
            $display("FAIL reset_vals: got wr=%b idx=%h d=%h b=%h busy=%b done=%b ovf=%b ir=%b cr=%b, required all 0 and cfg_ready=1",
                     wr_en, index, data_in, buf_idx, busy, done, overflow, in_ready, cfg_ready);
        end
    endtask

    task automatic test_basic();
        wq.delete(); dq.delete();
        tx = '{32'h11, 32'h22, 32'h33, 32'h44};
        send_desc(3'd0, 16'd0, 16'd4);
        stream(1'b0);
        idle(4);
        total++;
        if (wq.size() != 4) begin bad++; $display("FAIL basic_count: got %0d writes, required 4", wq.size()); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= wq.size() || wq[i].cyc != acc + 1 + i || wq[i].bank !== 3'd0 || wq[i].idx !== 16'(i) || wq[i].data !== tx[i]) begin
                bad++;
                $display("FAIL basic_wr%0d: got cyc=%0d bank=%0d idx=%0d data=%h, required cyc=%0d bank=0 idx=%0d data=%h",
                         i, wq[i].cyc, wq[i].bank, wq[i].idx, wq[i].data, acc + 1 + i, i, tx[i]);
            end
        end
        total++;
        if (dq.size() != 1 || dq[0] != acc + 5) begin
            bad++; $display("FAIL basic_done: got %0d pulses first at %0d, required 1 at %0d", dq.size(), dq[0], acc + 5);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[0][i] !== tx[i]) begin
                bad++; $display("FAIL basic_readback%0d: got %h, required %h", i, mem[0][i], tx[i]);
            end
        end
    endtask

    task automatic test_overflow();
        wq.delete(); dq.delete();
        tx = '{32'hA1, 32'hA2, 32'hA3};
        send_desc(3'd7, 16'd2047, 16'd3);
        stream(1'b0);
        idle(4);
        total++;
        if (wq.size() != 1 || wq[0].cyc != acc + 1 || wq[0].bank !== 3'd7 || wq[0].idx !== 16'd2047 || wq[0].data !== 32'hA1) begin
            bad++;
            $display("FAIL ovf_writes: got %0d writes first bank=%0d idx=%0d data=%h, required 1 write bank=7 idx=2047 data=a1",
                     wq.size(), wq[0].bank, wq[0].idx, wq[0].data);
        end
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
        total++;
        if (dq.size() != 1 || dq[0] != acc + 4) begin
            bad++; $display("FAIL ovf_done: got %0d pulses first at %0d, required 1 at %0d", dq.size(), dq[0], acc + 4);
        end
    endtask

    task automatic test_spill();
        logic [2:0]  eb[4];
        logic [15:0] ei[4];
        eb = '{3'd2, 3'd2, 3'd3, 3'd3};
        ei = '{16'd2046, 16'd2047, 16'd0, 16'd1};
        wq.delete(); dq.delete();
        tx = '{32'hB1, 32'hB2, 32'hB3, 32'hB4};
        send_desc(3'd2, 16'd2046, 16'd4);
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear_on_accept: got %b, required 0", overflow); end
        stream(1'b0);
        idle(4);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= wq.size() || wq[i].cyc != acc + 1 + i || wq[i].bank !== eb[i] || wq[i].idx !== ei[i] || wq[i].data !== tx[i]) begin
                bad++;
                $display("FAIL spill_wr%0d: got bank=%0d idx=%0d data=%h, required bank=%0d idx=%0d data=%h",
                         i, wq[i].bank, wq[i].idx, wq[i].data, eb[i], ei[i], tx[i]);
            end
        end
        total++;
        if (wq.size() != 4 || overflow !== 1'b0 || dq.size() != 1 || dq[0] != acc + 5) begin
            bad++;
            $display("FAIL spill_end: got writes=%0d ovf=%b done=%0d@%0d, required 4, 0, 1@%0d",
                     wq.size(), overflow, dq.size(), dq[0], acc + 5);
        end
    endtask

    task automatic test_stall();
        wq.delete(); dq.delete();
        tx = '{32'hC1, 32'hC2};
        send_desc(3'd4, 16'd10, 16'd2);
        stream(1'b1);
        idle(3);
        total++;
        if (wq.size() != 2 || wq[0].cyc != acc + 1 || wq[1].cyc != acc + 3 ||
            wq[0].idx !== 16'd10 || wq[1].idx !== 16'd11 || wq[0].bank !== 3'd4 || wq[1].data !== 32'hC2) begin
            bad++;
            $display("FAIL stall_writes: got n=%0d cyc=%0d,%0d idx=%0d,%0d, required n=2 cyc=%0d,%0d idx=10,11 bank=4",
                     wq.size(), wq[0].cyc, wq[1].cyc, wq[0].idx, wq[1].idx, acc + 1, acc + 3);
        end
        total++;
        if (dq.size() != 1 || dq[0] != acc + 4) begin
            bad++; $display("FAIL stall_done: got %0d pulses first at %0d, required 1 at %0d", dq.size(), dq[0], acc + 4);
        end
    endtask

    task automatic test_zero_len();
        wq.delete(); dq.delete();
        send_desc(3'd5, 16'd0, 16'd0);
        total++;
        if ({done, busy, cfg_ready, in_ready} !== 4'b1100) begin
            bad++; $display("FAIL zero_cycle: got done=%b busy=%b cr=%b ir=%b, required 1 1 0 0", done, busy, cfg_ready, in_ready);
        end
        idle(3);
        total++;
        if (wq.size() != 0 || dq.size() != 1 || dq[0] != acc) begin
            bad++; $display("FAIL zero_done: got writes=%0d done=%0d@%0d, required 0 writes, 1@%0d", wq.size(), dq.size(), dq[0], acc);
        end
    endtask

    task automatic test_reset_mid();
        wq.delete(); dq.delete();
        tx = '{32'hD0, 32'hD1, 32'hD2};
        send_desc(3'd1, 16'd100, 16'd8);
        stream(1'b0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({wr_en, index, data_in, buf_idx, busy, done, in_ready, cfg_ready} !== {1'b0, 16'h0, 32'h0, 3'h0, 4'b0001}) begin
            bad++;
            $display("FAIL reset_async: got wr=%b idx=%h d=%h b=%h busy=%b done=%b ir=%b cr=%b, required zeros and cfg_ready=1",
                     wr_en, index, data_in, buf_idx, busy, done, in_ready, cfg_ready);
        end
        #6 rst_n = 1'b1;
        idle(1);
        total++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_release: got cr=%b busy=%b, required 1 0", cfg_ready, busy);
        end
        idle(10);
        total++;
        if (dq.size() != 0 || wq.size() != 3) begin
            bad++; $display("FAIL reset_nodone: got done=%0d writes=%0d, required 0 and 3", dq.size(), wq.size());
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (mem[1][100 + i] !== tx[i]) begin
                bad++; $display("FAIL reset_kept%0d: got %h, required %h", i, mem[1][100 + i], tx[i]);
            end
        end
    endtask

`ifdef GBUF_LOADER_CSUM_EN
    task automatic test_csum();
        dq.delete();
        tx = '{32'hFFFF_FFFF, 32'h0000_0002};
        send_desc(3'd0, 16'd8, 16'd2);
        total++;
        if (csum !== 32'h0) begin bad++; $display("FAIL csum_clear: got %h, required 0", csum); end
        stream(1'b0);
        idle(3);
        total++;
        if (dq.size() != 1 || csum_at_done !== 32'h0000_0001) begin
            bad++; $display("FAIL csum_done: got %h (done=%0d), required 00000001", csum_at_done, dq.size());
        end
    endtask
`endif

    initial begin
        #2;
        test_reset();
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_overflow();
        test_spill();
        test_stall();
        test_zero_len();
        test_reset_mid();
`ifdef GBUF_LOADER_CSUM_EN
        test_csum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
